// File: rtl/cycle_steal_scheduler.sv
// Cycle-steal scheduler: freezes the pipeline, injects a counter-increment or
// interrupt op, waits for it to retire, then acknowledges the requester.
module cycle_steal_scheduler #(
  parameter int unsigned CNT_BASE  = 'o24,
  parameter int unsigned RUPT_BASE = 'o4004
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  cnt_req,
  input  logic [7:0]  cnt_dir,
  output logic [7:0]  cnt_ack,
  input  logic [4:0]  rupt_req,
  output logic [4:0]  rupt_ack,
  input  logic        inhibit_rupt,
  input  logic        resume,
  input  logic        pipe_empty,
  input  logic        steal_done,
  output logic        stall_req,
  output logic        steal_valid,
  output logic [1:0]  steal_op,
  output logic [11:0] steal_addr,
  output logic        in_isr
);

  typedef enum logic [2:0] {StIdle, StDrain, StIssue, StWait, StRelease} state_e;

  localparam logic [1:0] OpNone = 2'b00;
  localparam logic [1:0] OpPinc = 2'b01;
  localparam logic [1:0] OpMinc = 2'b10;
  localparam logic [1:0] OpRupt = 2'b11;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic        in_isr_q, in_isr_d;
  logic        stall_q, valid_q;
  logic [1:0]  sop_q;
  logic [11:0] saddr_q;
  logic [7:0]  cack_q;
  logic [4:0]  rack_q;
  logic [2:0]  cnt_idx, rupt_idx;
  logic        rupt_ok;

  // Fixed priority: scanning downward leaves the lowest set index.
  always_comb begin
    cnt_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (cnt_req[i]) cnt_idx = 3'(i);
    end
    rupt_idx = '0;
    for (int i = 4; i >= 0; i--) begin
      if (rupt_req[i]) rupt_idx = 3'(i);
    end
  end

  // Uses the registered in_isr, so a resume in this cycle cannot admit an interrupt.
  assign rupt_ok = (rupt_req != '0) && !inhibit_rupt && !in_isr_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (cnt_req != '0) begin
          state_d = StDrain;
          idx_d   = cnt_idx;
          op_d    = cnt_dir[cnt_idx] ? OpMinc : OpPinc;
          addr_d  = 12'(CNT_BASE + 32'(cnt_idx));
        end else if (rupt_ok) begin
          state_d = StDrain;
          idx_d   = rupt_idx;
          op_d    = OpRupt;
          addr_d  = 12'(RUPT_BASE + 32'({rupt_idx, 2'b00}));
        end
      end
      StDrain:   if (pipe_empty) state_d = StIssue;
      StIssue:   state_d = StWait;
      StWait:    if (steal_done) state_d = StRelease;
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    in_isr_d = in_isr_q;
    if (state_q == StRelease && op_q == OpRupt) begin
      in_isr_d = 1'b1;
    end else if (resume) begin
      in_isr_d = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      op_q     <= OpNone;
      addr_q   <= '0;
      in_isr_q <= 1'b0;
      stall_q  <= 1'b0;
      valid_q  <= 1'b0;
      sop_q    <= OpNone;
      saddr_q  <= '0;
      cack_q   <= '0;
      rack_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      in_isr_q <= in_isr_d;
      stall_q  <= (state_d == StDrain) || (state_d == StIssue) || (state_d == StWait);
      valid_q  <= (state_d == StIssue);
      sop_q    <= (state_d == StIssue) ? op_d : OpNone;
      saddr_q  <= (state_d == StIssue) ? addr_d : '0;
      cack_q   <= (state_d == StRelease && op_d != OpRupt) ? (8'(1) << idx_d) : '0;
      rack_q   <= (state_d == StRelease && op_d == OpRupt) ? (5'(1) << idx_d) : '0;
    end
  end

  assign stall_req   = stall_q;
  assign steal_valid = valid_q;
  assign steal_op    = sop_q;
  assign steal_addr  = saddr_q;
  assign cnt_ack     = cack_q;
  assign rupt_ack    = rack_q;
  assign in_isr      = in_isr_q;

endmodule
